// File: rtl/jedro_1_defines.sv
// Shared constants and types for the jedro_1 instruction fetch unit.
package jedro_1_defines;

   localparam int unsigned IFU_FIFO_DEPTH = 2;
   localparam logic [31:0] IFU_BOOT_ADDR  = 32'h0000_0000;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } ifu_state_e;

   // Redirect targets must sit on a 32-bit instruction boundary.
   function automatic logic is_word_aligned(input logic [1:0] lsb_i);
      return (lsb_i == 2'b00);
   endfunction

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Two-entry response buffer with synchronous flush; the head entry is read
// straight from storage so it stays stable until popped.
module jedro_1_ifu_fifo
   import jedro_1_defines::*;
#(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(IFU_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [IFU_FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o   = (cnt_q == '0);
   assign full_o    = (cnt_q == CNT_W'(IFU_FIFO_DEPTH));
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);
   assign data_o    = mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         else           wr_ptr_d = wr_ptr_q;
         if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         else           rd_ptr_d = rd_ptr_q;
         if (do_push_s && !do_pop_s)      cnt_d = cnt_q + CNT_W'(1);
         else if (!do_push_s && do_pop_s) cnt_d = cnt_q - CNT_W'(1);
         else                             cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < IFU_FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push_s && !flush_i) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/jedro_1_ifu.sv
// Instruction fetch unit: sequential fetch from a 1-cycle ROM into a 2-entry
// {pc, instr} buffer, with redirect, misaligned-redirect reporting and halt.
module jedro_1_ifu
   import jedro_1_defines::*;
#(
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = ADDR_WIDTH'(IFU_BOOT_ADDR)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic                  instr_en_o,
   output logic [ADDR_WIDTH-1:0] instr_addr_o,
   input  logic [DATA_WIDTH-1:0] instr_rdata_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   input  logic                  jmp_i,
   input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
   input  logic                  halt_i,
   output logic                  misaligned_o
);

   localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

   ifu_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
   logic                  inflight_q, inflight_d;
   logic                  discard_q, discard_d;
   logic                  misaligned_q, misaligned_d;

   logic                  run_s, room_s, fetch_en_s;
   logic                  jmp_ok_s, jmp_bad_s;
   logic                  fifo_push_s, fifo_pop_s, fifo_flush_s;
   logic                  fifo_full_s, fifo_empty_s;
   logic [ENTRY_W-1:0]    fifo_head_s;

   assign run_s     = (state_q == RUN) && !rst_i;
   assign jmp_ok_s  = run_s && !halt_i && jmp_i &&  is_word_aligned(jmp_addr_i[1:0]);
   assign jmp_bad_s = run_s && !halt_i && jmp_i && !is_word_aligned(jmp_addr_i[1:0]);

   // A fetch may go out only if its response is guaranteed a free slot.
   always_comb begin
      if (fifo_full_s)       room_s = fifo_pop_s && !inflight_q;
      else if (fifo_empty_s) room_s = 1'b1;
      else                   room_s = fifo_pop_s || !inflight_q;
   end

   assign fetch_en_s   = run_s && room_s;
   assign fifo_pop_s   = valid_o && ready_i;
   assign fifo_push_s  = inflight_q && !discard_q;
   assign fifo_flush_s = jmp_ok_s || halt_i || (state_q == HALT);

   always_comb begin
      state_d      = state_q;
      fetch_addr_d = fetch_addr_q;
      req_addr_d   = req_addr_q;
      inflight_d   = fetch_en_s;
      discard_d    = jmp_ok_s;
      misaligned_d = jmp_bad_s;
      case (state_q)
         RUN: begin
            if (halt_i) state_d = HALT;
            else        state_d = RUN;
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
      if (jmp_ok_s)        fetch_addr_d = jmp_addr_i;
      else if (fetch_en_s) fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
      else                 fetch_addr_d = fetch_addr_q;
      if (fetch_en_s) req_addr_d = fetch_addr_q;
      else            req_addr_d = req_addr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= RUN;
         fetch_addr_q <= BOOT_ADDR;
         req_addr_q   <= BOOT_ADDR;
         inflight_q   <= 1'b0;
         discard_q    <= 1'b0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_addr_q <= fetch_addr_d;
         req_addr_q   <= req_addr_d;
         inflight_q   <= inflight_d;
         discard_q    <= discard_d;
         misaligned_q <= misaligned_d;
      end
   end

   jedro_1_ifu_fifo #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (fifo_flush_s),
      .push_i  (fifo_push_s),
      .pop_i   (fifo_pop_s),
      .data_i  ({req_addr_q, instr_rdata_i}),
      .data_o  (fifo_head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   // Outputs are forced to their idle values for the whole reset window.
   assign instr_en_o   = fetch_en_s;
   assign instr_addr_o = rst_i ? BOOT_ADDR : fetch_addr_q;
   assign valid_o      = !fifo_empty_s && !rst_i;
   assign pc_o         = rst_i ? '0 : fifo_head_s[ENTRY_W-1 -: ADDR_WIDTH];
   assign instr_o      = rst_i ? '0 : fifo_head_s[DATA_WIDTH-1:0];
   assign misaligned_o = misaligned_q && !rst_i;

endmodule

// File: tb/tb_jedro_1_ifu.sv
// Scoreboard bench for jedro_1_ifu: a stream-level model predicts fetch
// addresses, delivered {pc, instr} order, redirect latency and pulses.
module tb_jedro_1_ifu;

   localparam logic [31:0] BOOT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_i, instr_en_o, valid_o, ready_i, jmp_i, halt_i, misaligned_o;
   logic [31:0] instr_addr_o, instr_rdata_i, instr_o, pc_o, jmp_addr_i;

   jedro_1_ifu #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (32),
      .BOOT_ADDR  (BOOT)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .instr_en_o    (instr_en_o),
      .instr_addr_o  (instr_addr_o),
      .instr_rdata_i (instr_rdata_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .jmp_i         (jmp_i),
      .jmp_addr_i    (jmp_addr_i),
      .halt_i        (halt_i),
      .misaligned_o  (misaligned_o)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];
   logic [31:0] next_pc = BOOT;
   logic [31:0] exp_fetch = BOOT;
   bit          halted = 1'b0, exp_mis = 1'b0, chk_fetch_now = 1'b0, flushed = 1'b0;
   int          deadline = -1, nogap_lo = -1, nogap_hi = -2;
   int          n_fetch = 0, base = 0, halt_cnt = 0;
   bit          p_rst = 1'b1, p_jmp = 1'b0, p_halt = 1'b0;
   logic [31:0] p_jaddr = 32'h0;
   bit          hold_prev = 1'b0;
   logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0, mon_e;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(next_pc);
         next_pc += 32'd4;
      end
   endtask

   // One clock of stimulus: first fold last cycle's inputs into the model.
   task automatic step(input bit rst, input bit jmp, input logic [31:0] jaddr, input bit halt, input bit rdy);
      @(posedge clk);
      cyc++;
      #1;
      exp_mis = 1'b0; chk_fetch_now = 1'b0; flushed = 1'b0;
      if (p_rst) begin
         halted = 1'b0; exp_q.delete(); next_pc = BOOT; exp_fetch = BOOT; flushed = 1'b1;
      end else if (halted) begin
         flushed = 1'b0;
      end else if (p_halt) begin
         halted = 1'b1; exp_q.delete(); flushed = 1'b1;
      end else if (p_jmp && p_jaddr[1:0] == 2'b00) begin
         exp_q.delete(); next_pc = p_jaddr; exp_fetch = p_jaddr; flushed = 1'b1;
         deadline = cyc + 2; chk_fetch_now = 1'b1;
      end else if (p_jmp) begin
         exp_mis = 1'b1;
      end
      refill();
      if (p_rst && !rst) begin
         deadline = cyc + 2; chk_fetch_now = 1'b1;
      end
      if (rst || halt || halted || (jmp && jaddr[1:0] == 2'b00)) deadline = -1;
      rst_i = rst; jmp_i = jmp; jmp_addr_i = jaddr; halt_i = halt; ready_i = rdy;
      p_rst = rst; p_jmp = jmp; p_jaddr = jaddr; p_halt = halt;
   endtask

   // ROM: answers each request one cycle later; unrequested cycles carry noise.
   initial begin
      logic        r_en;
      logic [31:0] r_addr;
      instr_rdata_i = 32'h0;
      forever begin
         @(negedge clk);
         r_en = instr_en_o; r_addr = instr_addr_o;
         @(posedge clk);
         #2;
         instr_rdata_i = r_en ? rom(r_addr) : $urandom;
      end
   end

   // Monitor: compares DUT outputs against the model every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_i) begin
            chk("rst_en", instr_en_o === 1'b0, 32'(instr_en_o), 32'h0);
            chk("rst_addr", instr_addr_o === BOOT, instr_addr_o, BOOT);
            chk("rst_valid", valid_o === 1'b0, 32'(valid_o), 32'h0);
            chk("rst_pc", pc_o === 32'h0, pc_o, 32'h0);
            chk("rst_instr", instr_o === 32'h0, instr_o, 32'h0);
            chk("rst_misaligned", misaligned_o === 1'b0, 32'(misaligned_o), 32'h0);
         end else begin
            chk("misaligned", misaligned_o === exp_mis, 32'(misaligned_o), 32'(exp_mis));
            if (halted) begin
               chk("halt_en", instr_en_o === 1'b0, 32'(instr_en_o), 32'h0);
               chk("halt_valid", valid_o === 1'b0, 32'(valid_o), 32'h0);
            end else begin
               if (chk_fetch_now)
                  chk("restart_fetch", instr_en_o === 1'b1 && instr_addr_o === exp_fetch, instr_addr_o, exp_fetch);
               if (instr_en_o === 1'b1) begin
                  chk("fetch_addr", instr_addr_o === exp_fetch, instr_addr_o, exp_fetch);
                  exp_fetch += 32'd4;
                  n_fetch++;
               end
               if (cyc == deadline - 1)
                  chk("early_valid", valid_o === 1'b0, 32'(valid_o), 32'h0);
               if (cyc == deadline)
                  chk("first_valid", valid_o === 1'b1 && pc_o === exp_q[0], pc_o, exp_q[0]);
               if (cyc >= nogap_lo && cyc <= nogap_hi)
                  chk("no_gap", valid_o === 1'b1, 32'(valid_o), 32'h1);
               if (hold_prev && !flushed)
                  chk("hold_stable", valid_o === 1'b1 && pc_o === prev_pc && instr_o === prev_instr, pc_o, prev_pc);
               if (valid_o === 1'b1 && ready_i === 1'b1) begin
                  if (exp_q.size() == 0) begin
                     chk("unexpected_valid", 1'b0, pc_o, 32'h0);
                  end else begin
                     mon_e = exp_q.pop_front();
                     chk("pc", pc_o === mon_e, pc_o, mon_e);
                     chk("instr", instr_o === rom(mon_e), instr_o, rom(mon_e));
                  end
               end
            end
         end
         hold_prev  = !rst_i && !halted && valid_o === 1'b1 && ready_i === 1'b0;
         prev_pc    = pc_o;
         prev_instr = instr_o;
      end
   end

   initial begin
      bit          r, j, h, rd;
      logic [31:0] a;
      rst_i = 1'b1; jmp_i = 1'b0; jmp_addr_i = 32'h0; halt_i = 1'b0; ready_i = 1'b0;
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

      // Back-to-back stream from boot, then a reset once 0x20 has been taken.
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      nogap_lo = cyc + 2; nogap_hi = cyc + 10;
      repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

      // Decoder stalled after boot: only two fetches may go out.
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      base = n_fetch;
      repeat (9) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      #1;
      chk("stall_fetches", (n_fetch - base) == 2, 32'(n_fetch - base), 32'd2);
      chk("stall_head", valid_o === 1'b1 && pc_o === BOOT, pc_o, BOOT);
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h42, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
      repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         if (halted) halt_cnt++;
         else        halt_cnt = 0;
         r  = ($urandom_range(99) < 2) || (halt_cnt > 8);
         j  = ($urandom_range(99) < 8);
         h  = ($urandom_range(999) < 5);
         rd = ($urandom_range(99) < 70);
         a  = $urandom & 32'h0000_FFFF;
         if ($urandom_range(1) == 0)  a[1:0] = 2'b00;
         if ($urandom_range(15) == 0) a = 32'hFFFF_FFF8;
         step(r, j, a, h, rd);
      end
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
